// File: rtl/mxint8_block_assembler_pkg.sv
// Shared MXINT8 constants for the block assembler and its output slot.
package mxint8_block_assembler_pkg;

  localparam int unsigned DefBlockSize    = 32;
  localparam int unsigned DefElementWidth = 8;
  localparam int unsigned DefScaleWidth   = 8;

  // E8M0 reserves the all-ones code as NaN.
  localparam logic [DefScaleWidth-1:0] ScaleNan = 8'hFF;

  function automatic int unsigned cnt_width(input int unsigned block_size);
    return (block_size > 1) ? $clog2(block_size) : 1;
  endfunction

endpackage

// File: rtl/mxint8_block_slot.sv
// Single-entry MX block holding register with valid/ready load, drain and reload.
module mxint8_block_slot
  import mxint8_block_assembler_pkg::*;
#(
  parameter int unsigned BLOCK_SIZE           = DefBlockSize,
  parameter int unsigned MXINT8_ELEMENT_WIDTH = DefElementWidth,
  parameter int unsigned MXINT8_SCALE_WIDTH   = DefScaleWidth
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_load,
  input  logic [MXINT8_ELEMENT_WIDTH-1:0] i_elements [BLOCK_SIZE-1:0],
  input  logic [MXINT8_SCALE_WIDTH-1:0]   i_scale,
  input  logic                            i_ready,
  output logic                            o_valid,
  output logic [MXINT8_ELEMENT_WIDTH-1:0] o_elements [BLOCK_SIZE-1:0],
  output logic [MXINT8_SCALE_WIDTH-1:0]   o_scale,
  output logic                            o_scale_nan
);

  logic                            valid_q, valid_d;
  logic [MXINT8_ELEMENT_WIDTH-1:0] elements_q [BLOCK_SIZE-1:0];
  logic [MXINT8_ELEMENT_WIDTH-1:0] elements_d [BLOCK_SIZE-1:0];
  logic [MXINT8_SCALE_WIDTH-1:0]   scale_q, scale_d;
  logic                            nan_q, nan_d;

  // A load in the same cycle as a drain wins, so the slot reloads without a bubble.
  always_comb begin
    valid_d    = valid_q;
    elements_d = elements_q;
    scale_d    = scale_q;
    nan_d      = nan_q;
    if (i_load) begin
      valid_d    = 1'b1;
      elements_d = i_elements;
      scale_d    = i_scale;
      nan_d      = &i_scale;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q    <= 1'b0;
      elements_q <= '{default: '0};
      scale_q    <= '0;
      nan_q      <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      elements_q <= elements_d;
      scale_q    <= scale_d;
      nan_q      <= nan_d;
    end
  end

  assign o_valid     = valid_q;
  assign o_elements  = elements_q;
  assign o_scale     = scale_q;
  assign o_scale_nan = nan_q;

endmodule

// File: rtl/mxint8_block_assembler.sv
// Serial element stream to MXINT8 block: fill counter and buffer, framing check,
// and an output slot feeding the combinational block operators.
module mxint8_block_assembler
  import mxint8_block_assembler_pkg::*;
#(
  parameter int unsigned BLOCK_SIZE           = DefBlockSize,
  parameter int unsigned MXINT8_ELEMENT_WIDTH = DefElementWidth,
  parameter int unsigned MXINT8_SCALE_WIDTH   = DefScaleWidth
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_element_valid,
  output logic                            o_element_ready,
  input  logic [MXINT8_ELEMENT_WIDTH-1:0] i_element_data,
  input  logic                            i_element_last,
  input  logic [MXINT8_SCALE_WIDTH-1:0]   i_scale,
  output logic                            o_block_valid,
  input  logic                            i_block_ready,
  output logic [MXINT8_ELEMENT_WIDTH-1:0] o_mxint8_elements [BLOCK_SIZE-1:0],
  output logic [MXINT8_SCALE_WIDTH-1:0]   o_scale,
  output logic                            o_scale_nan,
  output logic                            o_frame_error
);

  localparam int unsigned         CntWidth = cnt_width(BLOCK_SIZE);
  localparam logic [CntWidth-1:0] LastIdx  = CntWidth'(BLOCK_SIZE - 1);

  logic [CntWidth-1:0]             cnt_q, cnt_d;
  logic [MXINT8_ELEMENT_WIDTH-1:0] fill_q [BLOCK_SIZE-2:0];
  logic [MXINT8_ELEMENT_WIDTH-1:0] fill_d [BLOCK_SIZE-2:0];
  logic [MXINT8_SCALE_WIDTH-1:0]   scale_q, scale_d;
  logic                            ferr_q, ferr_d;
  logic                            accept, complete, block_valid;
  logic [MXINT8_ELEMENT_WIDTH-1:0] slot_elements [BLOCK_SIZE-1:0];

  // Only the completing element needs a free (or draining) slot.
  assign o_element_ready = (cnt_q != LastIdx) || !block_valid || i_block_ready;
  assign accept          = i_element_valid && o_element_ready;
  assign complete        = accept && (cnt_q == LastIdx);

  always_comb begin
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    scale_d = scale_q;
    ferr_d  = 1'b0;
    if (accept) begin
      if (cnt_q == '0) begin
        scale_d = i_scale;
      end
      if (cnt_q == LastIdx) begin
        cnt_d  = '0;
        ferr_d = !i_element_last;
      end else if (i_element_last) begin
        // Early last: drop the partial block and resynchronise on the next element.
        cnt_d  = '0;
        ferr_d = 1'b1;
      end else begin
        fill_d[cnt_q] = i_element_data;
        cnt_d         = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < BLOCK_SIZE - 1; i++) begin
      slot_elements[i] = fill_q[i];
    end
    slot_elements[BLOCK_SIZE-1] = i_element_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q   <= '0;
      fill_q  <= '{default: '0};
      scale_q <= '0;
      ferr_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      scale_q <= scale_d;
      ferr_q  <= ferr_d;
    end
  end

  mxint8_block_slot #(
    .BLOCK_SIZE          (BLOCK_SIZE),
    .MXINT8_ELEMENT_WIDTH(MXINT8_ELEMENT_WIDTH),
    .MXINT8_SCALE_WIDTH  (MXINT8_SCALE_WIDTH)
  ) u_slot (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (complete),
    .i_elements (slot_elements),
    .i_scale    (scale_q),
    .i_ready    (i_block_ready),
    .o_valid    (block_valid),
    .o_elements (o_mxint8_elements),
    .o_scale    (o_scale),
    .o_scale_nan(o_scale_nan)
  );

  assign o_block_valid = block_valid;
  assign o_frame_error = ferr_q;

endmodule

// File: tb/tb_mxint8_block_assembler.sv
// Self-checking bench: per-cycle vector table plus a block scoreboard, BLOCK_SIZE = 4.
module tb_mxint8_block_assembler;

  localparam int unsigned Bs = 4;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_element_valid;
  logic       o_element_ready;
  logic [7:0] i_element_data;
  logic       i_element_last;
  logic [7:0] i_scale;
  logic       o_block_valid;
  logic       i_block_ready;
  logic [7:0] o_mxint8_elements [Bs-1:0];
  logic [7:0] o_scale;
  logic       o_scale_nan;
  logic       o_frame_error;

  mxint8_block_assembler #(
    .BLOCK_SIZE          (Bs),
    .MXINT8_ELEMENT_WIDTH(8),
    .MXINT8_SCALE_WIDTH  (8)
  ) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_element_valid  (i_element_valid),
    .o_element_ready  (o_element_ready),
    .i_element_data   (i_element_data),
    .i_element_last   (i_element_last),
    .i_scale          (i_scale),
    .o_block_valid    (o_block_valid),
    .i_block_ready    (i_block_ready),
    .o_mxint8_elements(o_mxint8_elements),
    .o_scale          (o_scale),
    .o_scale_nan      (o_scale_nan),
    .o_frame_error    (o_frame_error)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       last;
    logic [7:0] scale;
    logic       bready;
    logic       exp_ready;   // before the edge
    logic       exp_bvalid;  // after the edge
    logic       exp_ferr;    // after the edge
  } vec_t;

  typedef struct {
    logic [31:0] elems;
    logic [7:0]  scale;
    logic        nan;
  } blk_t;

  blk_t        sb[$];
  vec_t        vecs[$];
  int          checks = 0;
  int          errors = 0;
  int          mcnt   = 0;
  logic [31:0] mbuf   = '0;
  logic [7:0]  mscale = '0;

  function automatic vec_t V(input logic v, input logic [7:0] d, input logic l,
                             input logic [7:0] s, input logic br, input logic er,
                             input logic ebv, input logic efe);
    vec_t r;
    r.valid = v; r.data = d; r.last = l; r.scale = s; r.bready = br;
    r.exp_ready = er; r.exp_bvalid = ebv; r.exp_ferr = efe;
    return r;
  endfunction

  function automatic logic [31:0] dut_elems();
    return {o_mxint8_elements[3], o_mxint8_elements[2],
            o_mxint8_elements[1], o_mxint8_elements[0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sb_pop();
    blk_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_block actual valid=1 required no block at %0t", $time);
    end else begin
      e = sb.pop_front();
      chk("block_elements", dut_elems(), e.elems);
      chk("block_scale", o_scale, e.scale);
      chk("block_scale_nan", o_scale_nan, e.nan);
    end
  endtask

  // Reference framing model driven only by the stimulus and the expected ready.
  task automatic model_accept(input logic [7:0] d, input logic l, input logic [7:0] s);
    blk_t b;
    if (mcnt == 0) mscale = s;
    if (mcnt == Bs - 1) begin
      mbuf[31:24] = d;
      b.elems = mbuf;
      b.scale = mscale;
      b.nan   = (mscale == 8'hFF);
      sb.push_back(b);
      mcnt = 0;
    end else if (l) begin
      mcnt = 0;
    end else begin
      mbuf[mcnt*8 +: 8] = d;
      mcnt++;
    end
  endtask

  task automatic cycle(input vec_t v);
    i_element_valid = v.valid;
    i_element_data  = v.data;
    i_element_last  = v.last;
    i_scale         = v.scale;
    i_block_ready   = v.bready;
    #2;
    chk("element_ready", o_element_ready, v.exp_ready);
    if (o_block_valid && v.bready) sb_pop();
    if (v.valid && v.exp_ready) model_accept(v.data, v.last, v.scale);
    @(posedge i_clk);
    #1;
    chk("block_valid", o_block_valid, v.exp_bvalid);
    chk("frame_error", o_frame_error, v.exp_ferr);
  endtask

  task automatic chk_reset_state();
    chk("rst_block_valid", o_block_valid, 1'b0);
    chk("rst_element_ready", o_element_ready, 1'b1);
    chk("rst_frame_error", o_frame_error, 1'b0);
    chk("rst_elements", dut_elems(), 32'h0);
    chk("rst_scale", o_scale, 8'h00);
    chk("rst_scale_nan", o_scale_nan, 1'b0);
  endtask

  initial begin
    i_rst = 1'b1; i_element_valid = 1'b0; i_element_data = '0;
    i_element_last = 1'b0; i_scale = '0; i_block_ready = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk_reset_state();
    i_rst = 1'b0;

    // Single block with sign/boundary values; scale only sampled at index 0.
    vecs.push_back(V(1, 8'h01, 0, 8'h7F, 1, 1, 0, 0));
    vecs.push_back(V(1, 8'h7F, 0, 8'hAA, 1, 1, 0, 0));
    vecs.push_back(V(1, 8'h80, 0, 8'hAA, 1, 1, 0, 0));
    vecs.push_back(V(1, 8'hFF, 1, 8'hAA, 1, 1, 1, 0));
    // Two back-to-back blocks, no stall.
    vecs.push_back(V(1, 8'h11, 0, 8'h05, 1, 1, 0, 0));
    vecs.push_back(V(1, 8'h22, 0, 8'hAA, 1, 1, 0, 0));
    vecs.push_back(V(1, 8'h33, 0, 8'hAA, 1, 1, 0, 0));
    vecs.push_back(V(1, 8'h44, 1, 8'hAA, 1, 1, 1, 0));
    vecs.push_back(V(1, 8'h55, 0, 8'h06, 1, 1, 0, 0));
    vecs.push_back(V(1, 8'h66, 0, 8'hAA, 1, 1, 0, 0));
    vecs.push_back(V(1, 8'h77, 0, 8'hAA, 1, 1, 0, 0));
    vecs.push_back(V(1, 8'h88, 1, 8'hAA, 1, 1, 1, 0));
    // Missing last on the completing element, NaN scale.
    vecs.push_back(V(1, 8'h01, 0, 8'hFF, 1, 1, 0, 0));
    vecs.push_back(V(1, 8'h02, 0, 8'hAA, 1, 1, 0, 0));
    vecs.push_back(V(1, 8'h03, 0, 8'hAA, 1, 1, 0, 0));
    vecs.push_back(V(1, 8'h04, 0, 8'hAA, 1, 1, 1, 1));
    vecs.push_back(V(0, 8'h00, 0, 8'h00, 1, 1, 0, 0));
    // Early last on the 2nd element, then a clean block.
    vecs.push_back(V(1, 8'hA1, 0, 8'h10, 1, 1, 0, 0));
    vecs.push_back(V(1, 8'hA2, 1, 8'hAA, 1, 1, 0, 1));
    vecs.push_back(V(1, 8'hB1, 0, 8'h20, 1, 1, 0, 0));
    vecs.push_back(V(1, 8'hB2, 0, 8'hAA, 1, 1, 0, 0));
    vecs.push_back(V(1, 8'hB3, 0, 8'hAA, 1, 1, 0, 0));
    vecs.push_back(V(1, 8'hB4, 1, 8'hAA, 1, 1, 1, 0));
    vecs.push_back(V(0, 8'h00, 0, 8'h00, 1, 1, 0, 0));
    foreach (vecs[i]) cycle(vecs[i]);

    // Back-pressure: A held, B fills to index 2, then completing element stalls.
    cycle(V(1, 8'hC0, 0, 8'h30, 0, 1, 0, 0));
    cycle(V(1, 8'hC1, 0, 8'hAA, 0, 1, 0, 0));
    cycle(V(1, 8'hC2, 0, 8'hAA, 0, 1, 0, 0));
    cycle(V(1, 8'hC3, 1, 8'hAA, 0, 1, 1, 0));
    cycle(V(1, 8'hD0, 0, 8'h31, 0, 1, 1, 0));
    cycle(V(1, 8'hD1, 0, 8'hAA, 0, 1, 1, 0));
    cycle(V(1, 8'hD2, 0, 8'hAA, 0, 1, 1, 0));
    cycle(V(1, 8'hD3, 1, 8'hAA, 0, 0, 1, 0));
    cycle(V(1, 8'hD3, 1, 8'hAA, 0, 0, 1, 0));
    chk("held_element0", o_mxint8_elements[0], 8'hC0);
    chk("held_scale", o_scale, 8'h30);
    cycle(V(1, 8'hD3, 1, 8'hAA, 1, 1, 1, 0));
    chk("reload_element3", o_mxint8_elements[3], 8'hD3);
    chk("reload_scale", o_scale, 8'h31);
    cycle(V(0, 8'h00, 0, 8'h00, 1, 1, 0, 0));

    // Reset mid-fill discards the partial block.
    cycle(V(1, 8'hE0, 0, 8'h50, 1, 1, 0, 0));
    cycle(V(1, 8'hE1, 0, 8'hAA, 1, 1, 0, 0));
    i_rst = 1'b1;
    i_element_valid = 1'b0;
    @(posedge i_clk);
    #1;
    chk_reset_state();
    @(posedge i_clk);
    #1;
    chk_reset_state();
    i_rst = 1'b0;
    mcnt = 0;
    sb.delete();
    cycle(V(1, 8'hF0, 0, 8'h40, 1, 1, 0, 0));
    cycle(V(1, 8'hF1, 0, 8'hAA, 1, 1, 0, 0));
    cycle(V(1, 8'hF2, 0, 8'hAA, 1, 1, 0, 0));
    cycle(V(1, 8'hF3, 1, 8'hAA, 1, 1, 1, 0));
    cycle(V(0, 8'h00, 0, 8'h00, 1, 1, 0, 0));

    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
